// File: rtl/learning_tutor_if.sv
// Song-memory, player-key and buzzer/LED/score signals of the learning tutor.
// The testbench or system side is the master; the tutor engine is the slave.
interface learning_tutor_if #(
    parameter int NOTE_W  = 4,
    parameter int DUR_W   = 26,
    parameter int ADDR_W  = 5,
    parameter int SCORE_W = 7
);
    logic               start;
    logic [NOTE_W-1:0]  note_value;
    logic [DUR_W-1:0]   duration_value;
    logic [NOTE_W-1:0]  user_input;
    logic [ADDR_W-1:0]  mem_addr;
    logic               key_on;
    logic [NOTE_W-1:0]  key;
    logic [SCORE_W-1:0] score;
    logic               busy;
    logic               done;
    logic               hit;
    logic               miss;

    modport master (
        output start, note_value, duration_value, user_input,
        input  mem_addr, key_on, key, score, busy, done, hit, miss
    );
    modport slave (
        input  start, note_value, duration_value, user_input,
        output mem_addr, key_on, key, score, busy, done, hit, miss
    );
endinterface

// File: rtl/learning_tutor.sv
// Learning-mode engine: plays each song note, waits for the matching key press,
// scores hits with a saturating counter, and handles rests, timeouts and strict replay.
module learning_tutor #(
    parameter int NOTE_W      = 4,
    parameter int DUR_W       = 26,
    parameter int ADDR_W      = 5,
    parameter int SCORE_W     = 7,
    parameter int TIMEOUT_CYC = 200_000_000,
    parameter bit STRICT      = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    learning_tutor_if.slave bus
);
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_PLAY, S_WAIT, S_ADVANCE, S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NOTE_W-1:0]  note_q, note_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [DUR_W-1:0]   dur_cnt_q, dur_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [NOTE_W-1:0]  prev_in_q, prev_in_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [NOTE_W-1:0]  key_q, key_d;
    logic               key_on_q, key_on_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               press;

    always_comb begin
        press      = (prev_in_q == '0) && (bus.user_input != '0);
        state_d    = state_q;
        note_d     = note_q;
        dur_d      = dur_q;
        dur_cnt_d  = dur_cnt_q;
        to_cnt_d   = '0;
        prev_in_d  = bus.user_input;
        mem_addr_d = mem_addr_q;
        score_d    = score_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    score_d    = '0;
                    mem_addr_d = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                note_d    = bus.note_value;
                dur_d     = bus.duration_value;
                dur_cnt_d = '0;
                state_d   = (bus.duration_value == '0) ? S_DONE : S_PLAY;
            end
            S_PLAY: begin
                if (dur_cnt_q == dur_q - DUR_W'(1))
                    state_d = (note_q == '0) ? S_ADVANCE : S_WAIT;
                else
                    dur_cnt_d = dur_cnt_q + DUR_W'(1);
            end
            S_WAIT: begin
                // Counter is 0 on entry, so the compare hits TIMEOUT_CYC edges after entry;
                // a press on that same edge takes priority over the timeout.
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (press && bus.user_input == note_q) begin
                    hit_d   = 1'b1;
                    score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
                    state_d = S_ADVANCE;
                end else if (press || to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    miss_d  = 1'b1;
                    state_d = STRICT ? S_FETCH : S_ADVANCE;
                end
            end
            S_ADVANCE: begin
                if (mem_addr_q == '1) begin
                    state_d = S_DONE;
                end else begin
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                    state_d    = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d   = state_d inside {S_FETCH, S_PLAY, S_WAIT, S_ADVANCE};
        done_d   = (state_d == S_DONE);
        key_d    = (state_d == S_PLAY || state_d == S_WAIT) ? note_d : '0;
        key_on_d = (state_d == S_PLAY) && (note_d != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            note_q     <= '0;
            dur_q      <= '0;
            dur_cnt_q  <= '0;
            to_cnt_q   <= '0;
            prev_in_q  <= '0;
            mem_addr_q <= '0;
            key_q      <= '0;
            key_on_q   <= 1'b0;
            score_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            note_q     <= note_d;
            dur_q      <= dur_d;
            dur_cnt_q  <= dur_cnt_d;
            to_cnt_q   <= to_cnt_d;
            prev_in_q  <= prev_in_d;
            mem_addr_q <= mem_addr_d;
            key_q      <= key_d;
            key_on_q   <= key_on_d;
            score_q    <= score_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
        end
    end

    // Buzzer is gated by reset so it goes quiet in the same cycle rst drops.
    assign bus.key_on   = key_on_q & rst;
    assign bus.key      = key_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.score    = score_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hit      = hit_q;
    assign bus.miss     = miss_q;
endmodule

// File: tb/tb_learning_tutor.sv
// Bench for learning_tutor: table of single-note lessons plus hand-written song,
// strict-replay, held-key, saturation and reset sequences; hit/miss pulses via a scoreboard.
module tb_learning_tutor;
    localparam int NW = 4, DW = 26, AW = 3, SW = 3, TO = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [NW-1:0] user_in = '0;
    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    learning_tutor_if #(.NOTE_W(NW), .DUR_W(DW), .ADDR_W(AW), .SCORE_W(SW)) ifa();
    learning_tutor_if #(.NOTE_W(NW), .DUR_W(DW), .ADDR_W(AW), .SCORE_W(SW)) ifb();

    learning_tutor #(.NOTE_W(NW), .DUR_W(DW), .ADDR_W(AW), .SCORE_W(SW),
                     .TIMEOUT_CYC(TO), .STRICT(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    learning_tutor #(.NOTE_W(NW), .DUR_W(DW), .ADDR_W(AW), .SCORE_W(SW),
                     .TIMEOUT_CYC(TO), .STRICT(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    logic [NW-1:0] song_note [8];
    logic [DW-1:0] song_dur  [8];

    assign ifa.start          = start;
    assign ifb.start          = start;
    assign ifa.user_input     = user_in;
    assign ifb.user_input     = user_in;
    assign ifa.note_value     = song_note[ifa.mem_addr];
    assign ifa.duration_value = song_dur[ifa.mem_addr];
    assign ifb.note_value     = song_note[ifb.mem_addr];
    assign ifb.duration_value = song_dur[ifb.mem_addr];

    typedef struct {
        logic hit;
        logic miss;
        int   at;
    } pulse_t;
    pulse_t exp_q[$];
    int keyon_by_key [16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every hit/miss pulse of the non-strict DUT must match the next expectation.
    initial begin
        pulse_t p;
        forever begin
            @(negedge clk);
            if (ifa.key_on) keyon_by_key[ifa.key] = keyon_by_key[ifa.key] + 1;
            if (ifa.hit || ifa.miss) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {ifa.hit, ifa.miss}, 2'b00);
                end else begin
                    p = exp_q.pop_front();
                    chk("pulse_kind", {ifa.hit, ifa.miss}, {p.hit, p.miss});
                    chk("pulse_cycle", cyc, p.at);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; user_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic clear_song();
        for (int i = 0; i < 8; i++) begin song_note[i] = '0; song_dur[i] = '0; end
        for (int i = 0; i < 16; i++) keyon_by_key[i] = 0;
    endtask

    task automatic load(input int idx, input logic [NW-1:0] n, input int d);
        song_note[idx] = n;
        song_dur[idx]  = DW'(d);
    endtask

    function automatic int keyon_total();
        int s = 0;
        for (int i = 0; i < 16; i++) s += keyon_by_key[i];
        return s;
    endfunction

    // Called at a negedge; t is the edge that samples start.
    task automatic kick(output int t);
        start = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push(input logic h, input logic m, input int at);
        pulse_t p;
        p.hit = h; p.miss = m; p.at = at;
        exp_q.push_back(p);
    endtask

    // Drive code so that it is sampled at edge 'edge_n'.
    task automatic press_at(input logic [NW-1:0] code, input int edge_n);
        while (cyc < edge_n - 1) @(negedge clk);
        user_in = code;
    endtask

    task automatic wait_prompt(output int e);
        bit ok = 1'b0;
        e = -1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (ifa.busy && !ifa.key_on && ifa.key != '0) begin ok = 1'b1; e = cyc; end
            else @(negedge clk);
        end
        if (!ok) chk("prompt_wait_expired", 0, 1);
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (ifa.done) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) chk("done_wait_expired", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [NW-1:0] note;
        int            dur;
        logic [NW-1:0] code;
        int            k;      // press edge offset from WAIT entry, 0 = no press
        logic          eh;
        logic          em;
        int            ek;     // pulse edge offset from WAIT entry
        int            score;
    } vec_t;

    initial begin
        vec_t vecs[7];
        int t, e, e2, m;

        vecs[0] = '{4'd5,  4, 4'd5,  2,  1'b1, 1'b0, 2,  1};
        vecs[1] = '{4'd5,  4, 4'd3,  1,  1'b0, 1'b1, 1,  0};
        vecs[2] = '{4'd7,  1, 4'd0,  0,  1'b0, 1'b1, 20, 0};
        vecs[3] = '{4'd7,  1, 4'd7,  20, 1'b1, 1'b0, 20, 1};
        vecs[4] = '{4'd3,  2, 4'd3,  19, 1'b1, 1'b0, 19, 1};
        vecs[5] = '{4'd0,  3, 4'd0,  0,  1'b0, 1'b0, 0,  0};
        vecs[6] = '{4'd15, 1, 4'd14, 5,  1'b0, 1'b1, 5,  0};

        clear_song();
        do_reset();
        chk("reset_outputs", {ifa.key_on, ifa.key, ifa.score, ifa.mem_addr,
                              ifa.busy, ifa.done, ifa.hit, ifa.miss}, 0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            clear_song();
            load(0, vecs[i].note, vecs[i].dur);
            kick(t);
            e = t + 1 + vecs[i].dur;
            if (vecs[i].eh || vecs[i].em) push(vecs[i].eh, vecs[i].em, e + vecs[i].ek);
            if (vecs[i].k > 0) begin
                press_at(vecs[i].code, e + vecs[i].k);
                @(negedge clk);
                user_in = '0;
            end
            wait_done();
            chk($sformatf("vec%0d_done", i), ifa.done, 1);
            chk($sformatf("vec%0d_score", i), ifa.score, vecs[i].score);
            chk($sformatf("vec%0d_addr", i), ifa.mem_addr, 1);
            chk($sformatf("vec%0d_keyon_cycles", i), keyon_total(),
                (vecs[i].note != 0) ? vecs[i].dur : 0);
            chk($sformatf("vec%0d_pending", i), exp_q.size(), 0);
        end

        // Full song with a rest, then restart from DONE.
        do_reset();
        clear_song();
        load(0, 4'd5, 4); load(1, 4'd0, 3); load(2, 4'd7, 2); load(3, 4'd0, 0);
        kick(t);
        wait_prompt(e);
        chk("song_wait1_entry", e, t + 5);
        push(1'b1, 1'b0, e + 1);
        user_in = 4'd5; @(negedge clk); user_in = '0;
        wait_prompt(e2);
        chk("song_wait2_entry", e2, e + 10);
        push(1'b1, 1'b0, e2 + 1);
        user_in = 4'd7; @(negedge clk); user_in = '0;
        wait_done();
        chk("song_score", ifa.score, 2);
        chk("song_addr", ifa.mem_addr, 3);
        chk("song_done", ifa.done, 1);
        chk("song_keyon_5", keyon_by_key[5], 4);
        chk("song_keyon_7", keyon_by_key[7], 2);
        chk("song_keyon_total", keyon_total(), 6);
        chk("song_pending", exp_q.size(), 0);
        kick(t);
        chk("restart_from_done", {ifa.busy, ifa.done, ifa.score, ifa.mem_addr}, {1'b1, 1'b0, 3'd0, 3'd0});

        // Wrong key: non-strict advances, strict replays the same address.
        do_reset();
        clear_song();
        load(0, 4'd5, 2); load(1, 4'd9, 1); load(2, 4'd0, 0);
        kick(t);
        wait_prompt(e);
        m = e + 1;
        push(1'b0, 1'b1, m);
        user_in = 4'd3; @(negedge clk); user_in = '0;
        chk("strict_miss_pulse", ifb.miss, 1);
        repeat (2) @(negedge clk);
        chk("nonstrict_next_key", ifa.key, 9);
        chk("nonstrict_next_addr", ifa.mem_addr, 1);
        chk("strict_replay", {ifb.key_on, ifb.key, ifb.mem_addr}, {1'b1, 4'd5, 3'd0});
        push(1'b0, 1'b1, m + 23);
        wait_done();
        chk("miss_score", ifa.score, 0);
        chk("miss_addr", ifa.mem_addr, 2);
        chk("miss_pending", exp_q.size(), 0);

        // Key held from PLAY into WAIT must be released and pressed again.
        do_reset();
        clear_song();
        load(0, 4'd5, 4); load(1, 4'd0, 0);
        kick(t);
        user_in = 4'd5;
        e = t + 5;
        push(1'b1, 1'b0, e + 9);
        press_at(4'd0, e + 6);
        chk("held_no_hit_score", ifa.score, 0);
        press_at(4'd5, e + 9);
        @(negedge clk); user_in = '0;
        wait_done();
        chk("held_score", ifa.score, 1);
        chk("held_pending", exp_q.size(), 0);

        // Eight hits with no end marker: score saturates, address stops at the top.
        do_reset();
        clear_song();
        for (int i = 0; i < 8; i++) load(i, 4'd1, 1);
        kick(t);
        for (int i = 0; i < 8; i++) begin
            wait_prompt(e);
            push(1'b1, 1'b0, e + 1);
            user_in = 4'd1; @(negedge clk); user_in = '0;
        end
        wait_done();
        chk("sat_score", ifa.score, 7);
        chk("sat_addr", ifa.mem_addr, 7);
        chk("sat_done", ifa.done, 1);
        chk("sat_pending", exp_q.size(), 0);

        // Reset in the middle of a note.
        do_reset();
        clear_song();
        load(0, 4'd5, 1); load(1, 4'd6, 10); load(2, 4'd0, 0);
        kick(t);
        wait_prompt(e);
        push(1'b1, 1'b0, e + 1);
        user_in = 4'd5; @(negedge clk); user_in = '0;
        repeat (4) @(negedge clk);
        chk("pre_reset_playing", {ifa.key_on, ifa.key, ifa.score, ifa.mem_addr}, {1'b1, 4'd6, 3'd1, 3'd1});
        rst = 1'b0;
        #1;
        chk("rst_buzzer_immediate", ifa.key_on, 0);
        @(negedge clk);
        chk("rst_mid_note_outputs", {ifa.key_on, ifa.key, ifa.score, ifa.mem_addr,
                                     ifa.busy, ifa.done, ifa.hit, ifa.miss}, 0);
        rst = 1'b1;

        // start pulsed during PLAY is ignored: full note length, then timeout.
        clear_song();
        load(0, 4'd5, 6); load(1, 4'd0, 0);
        kick(t);
        push(1'b0, 1'b1, t + 7 + TO);
        repeat (2) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_done();
        chk("ignored_start_keyon", keyon_by_key[5], 6);
        chk("ignored_start_addr", ifa.mem_addr, 1);
        chk("ignored_start_pending", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
